data_mem_responder: RTL and testbench

//  Memory-side responder for the pipeline's MEM-stage data port (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).

---
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage data responder: word-organised RAM with programmable wait states.
// Holds the pipeline through each access and rejects misaligned/out-of-range requests.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    generate
        if (LATENCY < 0 || LATENCY > 15 || ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_param_check
            $error("data_mem_responder: LATENCY must be 0..15 and ADDR_WIDTH 1..29");
        end
    endgenerate

    logic [31:0]           ram [0:DEPTH-1];
    logic                  req;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] req_idx;

    assign req     = mem_ren | mem_wen;
    assign req_idx = mem_addr[ADDR_WIDTH+1:2];
    // Both strobes at once is treated as a malformed request, not a read-modify-write.
    assign req_err = (mem_addr[1:0] != 2'b00) | (|mem_addr[31:ADDR_WIDTH+2]) | (mem_ren & mem_wen);

    generate
        if (LATENCY == 0) begin : g_comb
            always_ff @(posedge clk) begin
                if (rst_n && mem_wen && !req_err) begin
                    ram[req_idx] <= mem_dout;
                end
            end

            assign mem_din   = (mem_ren && !req_err) ? ram[req_idx] : 32'd0;
            assign mem_stall = 1'b0;
            assign mem_err   = req & req_err;
        end else begin : g_fsm
            localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

            state_t                state_reg;
            logic [3:0]            cnt_reg;
            logic [ADDR_WIDTH-1:0] idx_reg;
            logic [31:0]           data_reg;
            logic                  rd_reg;
            logic                  wr_reg;
            logic                  err_reg;
            logic [31:0]           rdata_reg;
            logic [ADDR_WIDTH-1:0] rd_idx;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    cnt_reg   <= 4'd0;
                    idx_reg   <= '0;
                    data_reg  <= 32'd0;
                    rd_reg    <= 1'b0;
                    wr_reg    <= 1'b0;
                    err_reg   <= 1'b0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (req) begin
                                idx_reg   <= req_idx;
                                data_reg  <= mem_dout;
                                rd_reg    <= mem_ren;
                                wr_reg    <= mem_wen;
                                err_reg   <= req_err;
                                cnt_reg   <= CNT_INIT;
                                state_reg <= (LATENCY == 1) ? DONE : BUSY;
                            end
                        end
                        BUSY: begin
                            cnt_reg <= cnt_reg - 4'd1;
                            if (cnt_reg == 4'd1) begin
                                state_reg <= DONE;
                            end
                        end
                        DONE: begin
                            cnt_reg   <= 4'd0;
                            state_reg <= IDLE;
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end

            // Read port samples every cycle; the value captured on entry to DONE is the
            // response. Writes only happen in DONE, so no read/write collision is possible.
            assign rd_idx = (state_reg == IDLE) ? req_idx : idx_reg;

            always_ff @(posedge clk) begin
                if (rst_n && state_reg == DONE && wr_reg && !err_reg) begin
                    ram[idx_reg] <= data_reg;
                end
                rdata_reg <= ram[rd_idx];
            end

            assign mem_stall = (state_reg == BUSY) || (state_reg == IDLE && req);
            assign mem_din   = (state_reg == DONE && rd_reg && !err_reg) ? rdata_reg : 32'd0;
            assign mem_err   = (state_reg == DONE) && err_reg;
        end
    endgenerate
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 0, 2, 3) driven through a
// reference word model; expected responses queue at issue and are checked at completion.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [3];
    logic        ren   [3];
    logic        wen   [3];
    logic [31:0] addr  [3];
    logic [31:0] dout  [3];
    logic [31:0] din   [3];
    logic        stall [3];
    logic        err   [3];

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst_n(rstn[0]), .mem_ren(ren[0]), .mem_wen(wen[0]), .mem_addr(addr[0]),
        .mem_dout(dout[0]), .mem_din(din[0]), .mem_stall(stall[0]), .mem_err(err[0])
    );
    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst_n(rstn[1]), .mem_ren(ren[1]), .mem_wen(wen[1]), .mem_addr(addr[1]),
        .mem_dout(dout[1]), .mem_din(din[1]), .mem_stall(stall[1]), .mem_err(err[1])
    );
    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rstn[2]), .mem_ren(ren[2]), .mem_wen(wen[2]), .mem_addr(addr[2]),
        .mem_dout(dout[2]), .mem_din(din[2]), .mem_stall(stall[2]), .mem_err(err[2])
    );

    typedef struct packed {
        logic [31:0] din;
        logic        err;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mdl [3][1024];
    int          lat_of [3] = '{0, 2, 3};
    int          checks = 0;
    int          errors = 0;

    task automatic drive(input int sel, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        ren[sel]  = r;
        wen[sel]  = w;
        addr[sel] = a;
        dout[sel] = d;
    endtask

    // One access on instance sel; expectation comes from the word model.
    task automatic access(input int sel, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d, input bit perturb);
        exp_t       e;
        logic [9:0] idx;
        int         stalls;
        bit         done;
        idx   = a[11:2];
        e.err = (a[1:0] != 2'b00) || (a[31:12] != 20'd0) || (r && w);
        e.din = (r && !e.err) ? mdl[sel][idx] : 32'd0;
        if (w && !e.err) mdl[sel][idx] = d;
        sb_q.push_back(e);
        @(posedge clk); #1;
        drive(sel, r, w, a, d);
        stalls = 0;
        done   = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (stall[sel]) begin
                stalls++;
                checks++;
                if (din[sel] !== 32'd0 || err[sel] !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_outputs lat%0d addr %h: din %h err %b, want din 0 err 0",
                             lat_of[sel], a, din[sel], err[sel]);
                end
                if (perturb && stalls == 1) begin
                    @(posedge clk); #1;
                    drive(sel, 1'b1, 1'b1, 32'h20, 32'hBADBAD00);
                end
            end else begin
                done = 1;
                e = sb_q.pop_front();
                checks++;
                if (din[sel] !== e.din) begin
                    errors++;
                    $display("FAIL resp_din lat%0d addr %h: got %h want %h", lat_of[sel], a, din[sel], e.din);
                end
                checks++;
                if (err[sel] !== e.err) begin
                    errors++;
                    $display("FAIL resp_err lat%0d addr %h: got %b want %b", lat_of[sel], a, err[sel], e.err);
                end
                checks++;
                if (stalls != lat_of[sel]) begin
                    errors++;
                    $display("FAIL stall_cycles lat%0d addr %h: got %0d want %0d", lat_of[sel], a, stalls, lat_of[sel]);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout lat%0d addr %h: no completion within 20 cycles", lat_of[sel], a);
            e = sb_q.pop_front();
        end
        $display("txn lat%0d ren %b wen %b addr %h dout %h -> din %h err %b stalls %0d",
                 lat_of[sel], r, w, a, d, din[sel], err[sel], stalls);
        if (lat_of[sel] != 0) drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            rstn[s] = 1'b0;
            drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks += 3;
            if (stall[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_stall lat%0d: got %b want 0", lat_of[s], stall[s]);
            end
            if (din[s] !== 32'd0) begin
                errors++;
                $display("FAIL reset_din lat%0d: got %h want 0", lat_of[s], din[s]);
            end
            if (err[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_err lat%0d: got %b want 0", lat_of[s], err[s]);
            end
        end
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) rstn[s] = 1'b1;
    endtask

    task automatic test_wait_states();
        access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
        access(2, 1'b0, 1'b1, 32'h14, 32'h600DCAFE, 1'b0);
        access(2, 1'b1, 1'b0, 32'h14, 32'd0, 1'b0);
    endtask

    task automatic test_single_cycle();
        access(0, 1'b0, 1'b1, 32'h4, 32'h12345678, 1'b0);
        access(0, 1'b1, 1'b0, 32'h4, 32'd0, 1'b0);
        access(0, 1'b0, 1'b1, 32'h0, 32'h0F0F0F0F, 1'b0);
        access(0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 1'b0);
        access(0, 1'b1, 1'b0, 32'h6, 32'd0, 1'b0);
        access(0, 1'b1, 1'b1, 32'h4, 32'h77777777, 1'b0);
        access(0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h4, 32'd0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_errors();
        access(1, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0);
        access(1, 1'b1, 1'b0, 32'h6, 32'd0, 1'b0);
        access(1, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 1'b0);
        access(1, 1'b0, 1'b1, 32'h8000_0000, 32'hEEEEEEEE, 1'b0);
        access(1, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
    endtask

    task automatic test_both_strobes();
        access(1, 1'b0, 1'b1, 32'h8, 32'h01020304, 1'b0);
        access(1, 1'b1, 1'b1, 32'h8, 32'h99999999, 1'b0);
        access(1, 1'b1, 1'b0, 32'h8, 32'd0, 1'b0);
    endtask

    task automatic test_busy_inputs();
        access(1, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0);
        access(1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1);
        access(1, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            access(1, 1'b0, 1'b1, 32'h100 + 32'(i * 4), d, 1'b0);
            access(1, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'd0, 1'b0);
            d = $urandom;
            access(2, 1'b0, 1'b1, 32'hFFC - 32'(i * 4), d, 1'b0);
            access(2, 1'b1, 1'b0, 32'hFFC - 32'(i * 4), 32'd0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        access(2, 1'b0, 1'b1, 32'hC, 32'h11112222, 1'b0);
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b1, 32'hC, 32'hAAAA5555);
        @(negedge clk);
        checks++;
        if (stall[2] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_accept: stall got %b want 1", stall[2]);
        end
        @(posedge clk); #1;
        rstn[2] = 1'b0;
        @(posedge clk); #1;
        rstn[2] = 1'b1;
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checks += 3;
        if (stall[2] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stall: got %b want 0", stall[2]);
        end
        if (din[2] !== 32'd0) begin
            errors++;
            $display("FAIL midreset_din: got %h want 0", din[2]);
        end
        if (err[2] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_err: got %b want 0", err[2]);
        end
        $display("txn lat3 reset during write 0xC <- aaaa5555 -> stall %b", stall[2]);
        access(2, 1'b1, 1'b0, 32'hC, 32'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_single_cycle();
        test_errors();
        test_both_strobes();
        test_busy_inputs();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
